led_pulse_stretch: RTL and testbench

Output-side companion to the switch debouncer: takes single-cycle event ticks (e.g. `db_tick` from a debounced button, or any internal strobe) and renders each one as a human-visible LED blink. Every tick produces one ON phase followed by a mandatory OFF gap. Ticks arriving while a blink is in progress are queued in a saturating pending counter; ticks beyond capacity are dropped and flagged. It sits between control logic and board LED pins.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_pulse_stretch_if.sv | 14 +
 rtl/led_pulse_stretch_phase_timer.sv | 27 ++
 rtl/led_pulse_stretch.sv | 106 ++++++++++
 tb/tb_led_pulse_stretch.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for LED / blink blocks: state encodings and a width helper.
package led_pkg;

  localparam logic [1:0] LED_ST_IDLE = 2'd0;
  localparam logic [1:0] LED_ST_ON   = 2'd1;
  localparam logic [1:0] LED_ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = LED_ST_IDLE,
    StOn   = LED_ST_ON,
    StGap  = LED_ST_GAP
  } led_state_e;

  function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_stretch_if.sv
// Event-in / LED-status-out bundle of the pulse stretcher.
interface led_pulse_stretch_if #(
  parameter int unsigned PEND_WIDTH = 4
);
  logic                  tick;
  logic                  led;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pending;
  logic                  drop;
  logic                  blink_done;

  modport master (output tick, input led, busy, pending, drop, blink_done);
  modport slave  (input tick, output led, busy, pending, drop, blink_done);
endinterface

// File: rtl/led_pulse_stretch_phase_timer.sv
// Loadable down-counter with zero flag; times the ON and GAP phases.
module phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_pulse_stretch.sv
// Renders single-cycle ticks as LED blinks (ON phase then OFF gap), queueing
// ticks that arrive mid-blink in a saturating pending counter.
module led_pulse_stretch
  import led_pkg::*;
#(
  parameter int unsigned ON_WIDTH   = 24,
  parameter int unsigned GAP_WIDTH  = 23,
  parameter int unsigned PEND_WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  led_pulse_stretch_if.slave bus
);

  localparam int unsigned TW = max_width(ON_WIDTH, GAP_WIDTH);
  localparam logic [TW-1:0] ON_LOAD  = {TW{1'b1}} >> (TW - ON_WIDTH);
  localparam logic [TW-1:0] GAP_LOAD = {TW{1'b1}} >> (TW - GAP_WIDTH);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  led_state_e            state_q, state_d;
  logic [PEND_WIDTH-1:0] pending_q, pending_d;
  logic                  drop_d;
  logic                  timer_load, timer_dec;
  logic [TW-1:0]         timer_val, count, next_count;
  logic                  zero;

  phase_timer #(
    .WIDTH (TW)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_val),
    .dec        (timer_dec),
    .count      (count),
    .zero       (zero)
  );

  // Next state, pending queue update and timer control.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    drop_d     = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    timer_val  = ON_LOAD;
    unique case (state_q)
      StIdle: begin
        if (bus.tick) begin
          state_d    = StOn;
          timer_load = 1'b1;
        end
      end
      StOn, StGap: begin
        if (!zero) begin
          timer_dec = 1'b1;
        end else if (state_q == StOn) begin
          state_d    = StGap;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
        if (zero && state_q == StGap) begin
          // End of blink: a queued blink wins; a coincident tick offsets the decrement.
          if (pending_q != '0) begin
            state_d    = StOn;
            timer_load = 1'b1;
            if (!bus.tick) pending_d = pending_q - PEND_WIDTH'(1);
          end else if (bus.tick) begin
            state_d    = StOn;
            timer_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (bus.tick) begin
          if (pending_q != PEND_MAX) pending_d = pending_q + PEND_WIDTH'(1);
          else drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign next_count = timer_load ? timer_val : (timer_dec ? count - TW'(1) : count);

  // State and registered outputs; blink_done marks the final GAP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      bus.led        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.pending    <= '0;
      bus.drop       <= 1'b0;
      bus.blink_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      bus.led        <= (state_d == StOn);
      bus.busy       <= (state_d != StIdle);
      bus.pending    <= pending_d;
      bus.drop       <= drop_d;
      bus.blink_done <= (state_d == StGap) && (next_count == '0);
    end
  end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Self-checking bench for led_pulse_stretch with ON=4, GAP=2, pending max 3.
module tb_led_pulse_stretch;

  localparam int ON_W   = 2;
  localparam int GAP_W  = 1;
  localparam int PEND_W = 2;
  localparam int ON_LEN = 1 << ON_W;
  localparam int PERIOD = (1 << ON_W) + (1 << GAP_W);
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pulse_stretch_if #(.PEND_WIDTH(PEND_W)) bus ();

  led_pulse_stretch #(
    .ON_WIDTH   (ON_W),
    .GAP_WIDTH  (GAP_W),
    .PEND_WIDTH (PEND_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current blink period (-1 = idle).
  int m_pos, m_pend, m_drop;

  task automatic model_reset();
    m_pos = -1; m_pend = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit t);
    m_drop = 0;
    if (m_pos < 0) begin
      if (t) m_pos = 0;
    end else if (m_pos == PERIOD - 1) begin
      if (m_pend > 0) begin
        m_pos = 0;
        if (!t) m_pend--;
      end else if (t) m_pos = 0;
      else m_pos = -1;
    end else begin
      m_pos++;
      if (t) begin
        if (m_pend < PMAX) m_pend++;
        else m_drop = 1;
      end
    end
  endtask

  task automatic check_model();
    check("rnd_led", int'(bus.led), int'(m_pos >= 0 && m_pos < ON_LEN));
    check("rnd_busy", int'(bus.busy), int'(m_pos >= 0));
    check("rnd_pending", int'(bus.pending), m_pend);
    check("rnd_drop", int'(bus.drop), m_drop);
    check("rnd_done", int'(bus.blink_done), int'(m_pos == PERIOD - 1));
  endtask

  // Drive tick for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit t);
    @(negedge clk);
    bus.tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.tick = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit tick;
    bit led;
    bit busy;
    int pend;
    bit drop;
    bit done;
  } vec_t;

  vec_t tbl[14];
  int   drops, dones, leds, maxp;
  bit   t;
  int   dens;

  initial begin
    bus.tick = 1'b0;
    reset    = 1'b0;

    // Ticks at relative cycles 0 and 2: second blink follows the first gap directly.
    tbl[0]  = '{1, 1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 1};
    tbl[6]  = '{0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0};

    #1;
    check("rst_led", int'(bus.led), 0);
    check("rst_busy", int'(bus.busy), 0);
    do_reset();
    step(1'b0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_drop", int'(bus.drop), 0);
    check("rst_done", int'(bus.blink_done), 0);
    check("rst_led2", int'(bus.led), 0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].tick);
      check($sformatf("tbl%0d_led", i), int'(bus.led), int'(tbl[i].led));
      check($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
      check($sformatf("tbl%0d_pending", i), int'(bus.pending), tbl[i].pend);
      check($sformatf("tbl%0d_drop", i), int'(bus.drop), int'(tbl[i].drop));
      check($sformatf("tbl%0d_done", i), int'(bus.blink_done), int'(tbl[i].done));
    end

    // Tick held for six cycles: saturates at 3, two drops, four blinks.
    do_reset();
    drops = 0; dones = 0; maxp = 0;
    for (int i = 0; i < 40; i++) begin
      step(i < 6);
      drops += int'(bus.drop);
      dones += int'(bus.blink_done);
      if (int'(bus.pending) > maxp) maxp = int'(bus.pending);
    end
    check("held_drops", drops, 2);
    check("held_blinks", dones, 4);
    check("held_maxpend", maxp, 3);

    // Tick in the last GAP cycle with nothing pending restarts ON directly.
    do_reset();
    step(1'b1);
    for (int i = 1; i <= 5; i++) step(1'b0);
    check("gapend0_done", int'(bus.blink_done), 1);
    step(1'b1);
    check("gapend0_led", int'(bus.led), 1);
    check("gapend0_pending", int'(bus.pending), 0);
    check("gapend0_drop", int'(bus.drop), 0);

    // Tick in a GAP-end cycle with a full queue: net zero, no drop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1);
    check("full_pending", int'(bus.pending), 3);
    step(1'b0);
    step(1'b0);
    check("full_done", int'(bus.blink_done), 1);
    step(1'b1);
    check("full_gapend_pending", int'(bus.pending), 3);
    check("full_gapend_drop", int'(bus.drop), 0);
    check("full_gapend_led", int'(bus.led), 1);

    // Asynchronous reset mid-ON with two queued blinks.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1);
    check("mid_pending", int'(bus.pending), 2);
    @(negedge clk);
    bus.tick = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_led", int'(bus.led), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_pending", int'(bus.pending), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    dones = 0; leds = 0;
    step(1'b1);
    leds += int'(bus.led);
    for (int i = 0; i < 15; i++) begin
      step(1'b0);
      leds += int'(bus.led);
      dones += int'(bus.blink_done);
    end
    check("post_rst_blinks", dones, 1);
    check("post_rst_led_cycles", leds, 4);
    check("post_rst_busy", int'(bus.busy), 0);

    // Randomized traffic against the reference model, density varied per block.
    do_reset();
    model_reset();
    dens = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) dens = $urandom_range(0, 100);
      t = ($urandom_range(0, 99) < dens);
      step(t);
      model_step(t);
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
